// File: rtl/omem_pkg.sv
// Shared definitions for the output-memory packet protocol: field layout,
// opcode helpers, packet type and the client FSM state encoding.
package omem_pkg;

  localparam int PKT_W   = 33;
  localparam int DEST_HI = 32;
  localparam int DEST_LO = 29;
  localparam int OPC_HI  = 28;
  localparam int OPC_LO  = 25;
  localparam int DATA_W  = 25;

  localparam int SUM_WIDTH = 13;

  localparam logic [3:0] OPC_TS_DONE = 4'd15;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_ST,
    S_SEND_RQ,
    S_WAIT_RSP,
    S_WAIT_TS,
    S_FINISH
  } state_t;

  // Each SPE owns an opcode pair: even = store, odd = previous-spike request.
  function automatic logic [3:0] opc_send(input int spe_id);
    return 4'(2 * spe_id);
  endfunction

  function automatic logic [3:0] opc_req(input int spe_id);
    return 4'(2 * spe_id + 1);
  endfunction

endpackage

// File: rtl/omem_client_pkt_encode.sv
// Combinational packet builder: concatenates dest, opcode and payload.
module pkt_encode
  import omem_pkg::*;
(
  input  logic [3:0]        dest,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] data,
  output pkt_t              pkt
);

  assign pkt = {dest, opcode, data};

endmodule

// File: rtl/omem_client.sv
// SPE-side initiator: turns core store/request events into output-memory
// packets, returns spike responses and follows the two-timestep schedule.
module omem_client #(
  parameter int SPE_ID      = 0,
  parameter int NODE_ADDR   = 0,
  parameter int OMEM_ADDR   = 11,
  parameter int SUM_WIDTH   = 13,
  parameter int NUM_OUTPUTS = 441,
  parameter int STRIDE      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [SUM_WIDTH-1:0] st_potential,
  input  logic                 st_spike,
  input  logic                 rq_valid,
  output logic                 rq_ready,
  output logic                 rsp_valid,
  output logic                 rsp_spike,
  output logic                 ts_done,
  output logic [1:0]           cur_ts,
  output logic                 all_done,
  output logic                 err,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [32:0]          tx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [32:0]          rx_data
);
  import omem_pkg::*;

  // Neurons are interleaved across SPEs, so lower SPE ids may own one extra.
  localparam int N_STORES = (NUM_OUTPUTS - SPE_ID + STRIDE - 1) / STRIDE;
  localparam int CNT_W    = $clog2(N_STORES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STORES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   store_cnt;
  logic               ts2;

  logic [3:0]         rx_dest, rx_opc;
  logic               rx_for_us, ts_hit, rsp_hit, rx_bad;
  logic               accept_rq, accept_st;
  logic [3:0]         enc_opc;
  logic [DATA_W-1:0]  enc_data;
  pkt_t               enc_pkt;
  logic               unused_rx_payload;

  assign rx_dest   = rx_data[DEST_HI:DEST_LO];
  assign rx_opc    = rx_data[OPC_HI:OPC_LO];
  assign rx_for_us = rx_valid && (rx_dest == 4'(NODE_ADDR));
  assign ts_hit    = rx_for_us && (rx_opc == OPC_TS_DONE) && (state == S_WAIT_TS);
  assign rsp_hit   = rx_for_us && (rx_opc != OPC_TS_DONE) && (state == S_WAIT_RSP);
  // Anything arriving that is neither the awaited response nor the awaited
  // TIMESTEP_DONE is a protocol violation and is otherwise dropped.
  assign rx_bad    = rx_valid && !ts_hit && !rsp_hit;

  assign unused_rx_payload = ^rx_data[DATA_W-1:1];

  assign st_ready = (state == S_IDLE);
  assign rq_ready = (state == S_IDLE) && ts2;
  assign rx_ready = 1'b1;
  assign tx_valid = (state == S_SEND_ST) || (state == S_SEND_RQ);
  assign all_done = (state == S_FINISH);
  assign cur_ts   = ts2 ? 2'd2 : 2'd1;

  // A request wins over a simultaneous store.
  assign accept_rq = rq_valid && rq_ready;
  assign accept_st = st_valid && st_ready && !accept_rq;

  assign enc_opc  = accept_rq ? opc_req(SPE_ID) : opc_send(SPE_ID);
  assign enc_data = accept_rq ? '0 : DATA_W'({st_potential, st_spike});

  pkt_encode u_pkt_encode (
    .dest   (4'(OMEM_ADDR)),
    .opcode (enc_opc),
    .data   (enc_data),
    .pkt    (enc_pkt)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_rq)      state_nxt = S_SEND_RQ;
        else if (accept_st) state_nxt = S_SEND_ST;
      end
      S_SEND_ST: begin
        if (tx_ready) begin
          if (store_cnt == CNT_LAST) state_nxt = ts2 ? S_FINISH : S_WAIT_TS;
          else                       state_nxt = S_IDLE;
        end
      end
      S_SEND_RQ:  if (tx_ready) state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: if (rsp_hit)  state_nxt = S_IDLE;
      S_WAIT_TS:  if (ts_hit)   state_nxt = S_IDLE;
      S_FINISH:   state_nxt = S_FINISH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_cnt <= '0;
      ts2       <= 1'b0;
      tx_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_spike <= 1'b0;
      ts_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= rsp_hit;
      ts_done   <= ts_hit;
      if (rsp_hit) rsp_spike <= rx_data[0];
      if (rx_bad)  err <= 1'b1;
      // Packet is frozen at acceptance so tx_data stays stable under stall.
      if (accept_rq || accept_st) tx_data <= enc_pkt;
      if ((state == S_SEND_ST) && tx_ready) store_cnt <= store_cnt + 1'b1;
      if (ts_hit) begin
        ts2       <= 1'b1;
        store_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_omem_client.sv
// Randomized bench for omem_client: two instances (SPE 0 and SPE 4) checked
// every cycle against a transaction-level protocol model.
module tb_omem_client;

  localparam int OMEM = 11;
  localparam int SPE  [2] = '{0, 4};
  localparam int NODE [2] = '{3, 7};

  typedef enum int {P_READY, P_TX, P_AWAIT_RSP, P_AWAIT_TS, P_DONE} phase_t;

  logic        clk = 1'b0;
  logic        reset        [2];
  logic        st_valid     [2];
  logic        st_ready     [2];
  logic [12:0] st_potential [2];
  logic        st_spike     [2];
  logic        rq_valid     [2];
  logic        rq_ready     [2];
  logic        rsp_valid    [2];
  logic        rsp_spike    [2];
  logic        ts_done      [2];
  logic [1:0]  cur_ts       [2];
  logic        all_done     [2];
  logic        err          [2];
  logic        tx_valid     [2];
  logic        tx_ready     [2];
  logic [32:0] tx_data      [2];
  logic        rx_valid     [2];
  logic        rx_ready     [2];
  logic [32:0] rx_data      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    omem_client #(
      .SPE_ID(SPE[g]), .NODE_ADDR(NODE[g]), .OMEM_ADDR(OMEM),
      .SUM_WIDTH(13), .NUM_OUTPUTS(441), .STRIDE(5)
    ) u_dut (
      .clk(clk), .reset(reset[g]),
      .st_valid(st_valid[g]), .st_ready(st_ready[g]),
      .st_potential(st_potential[g]), .st_spike(st_spike[g]),
      .rq_valid(rq_valid[g]), .rq_ready(rq_ready[g]),
      .rsp_valid(rsp_valid[g]), .rsp_spike(rsp_spike[g]),
      .ts_done(ts_done[g]), .cur_ts(cur_ts[g]),
      .all_done(all_done[g]), .err(err[g]),
      .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_data(tx_data[g]),
      .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]), .rx_data(rx_data[g])
    );
  end

  // Protocol model state
  phase_t      m_phase   [2];
  logic [32:0] m_pkt     [2];
  logic [1:0]  m_ts      [2];
  int          m_cnt     [2];
  logic        m_err     [2];
  logic        m_spike   [2];
  int          m_rsp_cyc [2];
  int          m_tsd_cyc [2];
  logic [32:0] last_tx   [2];

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_stores(input int id);
    return (441 - id + 5 - 1) / 5;
  endfunction

  function automatic logic [32:0] store_pkt(input int id, input int pot, input bit spk);
    return {4'(OMEM), 4'(2 * id), 25'((pot << 1) | int'(spk))};
  endfunction

  function automatic logic [32:0] req_pkt(input int id);
    return {4'(OMEM), 4'(2 * id + 1), 25'd0};
  endfunction

  task automatic check(input string name, input int inst, input logic [32:0] act,
                       input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int i);
    m_phase[i] = P_READY; m_pkt[i] = '0; m_ts[i] = 2'd1; m_cnt[i] = 0;
    m_err[i] = 1'b0; m_spike[i] = 1'b0; m_rsp_cyc[i] = -1; m_tsd_cyc[i] = -1;
  endtask

  task automatic do_reset(input int i);
    reset[i] = 1'b1; st_valid[i] = 1'b0; rq_valid[i] = 1'b0;
    tx_ready[i] = 1'b0; rx_valid[i] = 1'b0;
    tick();
    reset[i] = 1'b0;
    model_reset(i);
  endtask

  // Randomly stalls the router, then completes the handshake.
  task automatic wait_tx(input int i);
    for (int k = 0; k < 8; k++) begin
      tx_ready[i] = (k >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      if (tx_ready[i]) last_tx[i] = tx_data[i];
      tick();
      if (tx_ready[i]) break;
    end
    tx_ready[i] = 1'b0;
  endtask

  task automatic do_store(input int i, input int pot, input bit spk);
    st_potential[i] = 13'(pot); st_spike[i] = spk; st_valid[i] = 1'b1;
    tick();
    st_valid[i] = 1'b0;
    m_phase[i] = P_TX; m_pkt[i] = store_pkt(SPE[i], pot, spk);
    wait_tx(i);
    m_cnt[i]++;
    if (m_cnt[i] == n_stores(SPE[i])) m_phase[i] = (m_ts[i] == 2'd1) ? P_AWAIT_TS : P_DONE;
    else                              m_phase[i] = P_READY;
  endtask

  task automatic send_rx(input int i, input int dest, input int opc, input bit bit0);
    rx_data[i] = {4'(dest), 4'(opc), 24'($urandom), bit0};
    rx_valid[i] = 1'b1;
    tick();
    rx_valid[i] = 1'b0;
    if (dest != NODE[i]) m_err[i] = 1'b1;
    else if (opc == 15) begin
      if (m_phase[i] == P_AWAIT_TS) begin
        m_ts[i] = 2'd2; m_cnt[i] = 0; m_phase[i] = P_READY; m_tsd_cyc[i] = cyc;
      end else m_err[i] = 1'b1;
    end else begin
      if (m_phase[i] == P_AWAIT_RSP) begin
        m_spike[i] = bit0; m_phase[i] = P_READY; m_rsp_cyc[i] = cyc;
      end else m_err[i] = 1'b1;
    end
  endtask

  task automatic do_request(input int i, input bit spk);
    rq_valid[i] = 1'b1;
    tick();
    rq_valid[i] = 1'b0;
    m_phase[i] = P_TX; m_pkt[i] = req_pkt(SPE[i]);
    wait_tx(i);
    m_phase[i] = P_AWAIT_RSP;
    repeat ($urandom_range(0, 3)) tick();
    send_rx(i, NODE[i], $urandom_range(0, 14), spk);
  endtask

  // Request and store raised together: request first, store after response.
  task automatic do_both(input int i, input int pot, input bit spk);
    st_potential[i] = 13'(pot); st_spike[i] = spk; st_valid[i] = 1'b1;
    do_request(i, 1'($urandom_range(0, 1)));
    do_store(i, pot, spk);
  endtask

  task automatic run_ts2(input int i);
    int r, pot;
    while (m_cnt[i] < n_stores(SPE[i])) begin
      r = $urandom_range(0, 3);
      pot = $urandom_range(0, 8191);
      if (r == 0)      do_request(i, 1'($urandom_range(0, 1)));
      else if (r == 1) do_both(i, pot, 1'(pot));
      else             do_store(i, pot, 1'(pot));
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          check("st_ready",  i, 33'(st_ready[i]),  33'(m_phase[i] == P_READY));
          check("rq_ready",  i, 33'(rq_ready[i]),  33'(m_phase[i] == P_READY && m_ts[i] == 2'd2));
          check("tx_valid",  i, 33'(tx_valid[i]),  33'(m_phase[i] == P_TX));
          if (m_phase[i] == P_TX) check("tx_data", i, tx_data[i], m_pkt[i]);
          check("cur_ts",    i, 33'(cur_ts[i]),    33'(m_ts[i]));
          check("all_done",  i, 33'(all_done[i]),  33'(m_phase[i] == P_DONE));
          check("err",       i, 33'(err[i]),       33'(m_err[i]));
          check("rx_ready",  i, 33'(rx_ready[i]),  33'(1'b1));
          check("rsp_valid", i, 33'(rsp_valid[i]), 33'(m_rsp_cyc[i] == cyc));
          check("ts_done",   i, 33'(ts_done[i]),   33'(m_tsd_cyc[i] == cyc));
          check("rsp_spike", i, 33'(rsp_spike[i]), 33'(m_spike[i]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; st_valid[i] = 1'b0; st_potential[i] = '0; st_spike[i] = 1'b0;
      rq_valid[i] = 1'b0; tx_ready[i] = 1'b0; rx_valid[i] = 1'b0; rx_data[i] = '0;
      last_tx[i] = '0;
      model_reset(i);
    end
    tick();
    reset[0] = 1'b0; reset[1] = 1'b0;
    chk_en = 1'b1;

    check("rst_st_ready", 0, 33'(st_ready[0]), 33'd1);
    check("rst_rq_ready", 0, 33'(rq_ready[0]), 33'd0);
    check("rst_tx_data",  0, tx_data[0], 33'd0);

    // SPE0 timestep 1: potential=i, spike=i[0]
    for (int k = 0; k < 89; k++) begin
      do_store(0, k, 1'(k));
      if (k == 5) check("store5_pkt", 0, last_tx[0], 33'h1_6000_000B);
    end
    check("ts1_full_st_ready", 0, 33'(st_ready[0]), 33'd0);
    check("ts1_full_cur_ts",   0, 33'(cur_ts[0]), 33'd1);
    st_valid[0] = 1'b1;
    repeat (4) tick();
    st_valid[0] = 1'b0;

    send_rx(0, NODE[0], 15, 1'b0);
    check("tsd_pulse",  0, 33'(ts_done[0]), 33'd1);
    check("tsd_cur_ts", 0, 33'(cur_ts[0]), 33'd2);

    do_request(0, 1'b1);
    check("req_pkt",   0, last_tx[0], 33'h1_6200_0000);
    check("rsp_pulse", 0, 33'(rsp_valid[0]), 33'd1);
    check("rsp_bit",   0, 33'(rsp_spike[0]), 33'd1);
    do_both(0, 1234, 1'b0);
    run_ts2(0);
    check("spe0_all_done", 0, 33'(all_done[0]), 33'd1);

    // SPE4 through both timesteps
    for (int k = 0; k < 88; k++) do_store(1, $urandom_range(0, 8191), 1'($urandom_range(0, 1)));
    repeat (2) tick();
    send_rx(1, NODE[1], 15, 1'b1);
    run_ts2(1);
    check("spe4_all_done", 1, 33'(all_done[1]), 33'd1);
    st_valid[1] = 1'b1;
    repeat (5) tick();
    st_valid[1] = 1'b0;

    // Error paths and reset during a stalled packet
    do_reset(1);
    send_rx(1, NODE[1], 15, 1'b0);
    check("tsd_outside_err", 1, 33'(err[1]), 33'd1);
    do_reset(1);
    st_potential[1] = 13'd4321; st_spike[1] = 1'b1; st_valid[1] = 1'b1;
    tick();
    st_valid[1] = 1'b0;
    m_phase[1] = P_TX; m_pkt[1] = store_pkt(SPE[1], 4321, 1'b1);
    repeat (10) tick();
    send_rx(1, NODE[1], 3, 1'b1);
    check("unsolicited_err", 1, 33'(err[1]), 33'd1);
    tick();
    do_reset(1);
    check("post_rst_tx_valid", 1, 33'(tx_valid[1]), 33'd0);
    check("post_rst_tx_data",  1, tx_data[1], 33'd0);
    check("post_rst_err",      1, 33'(err[1]), 33'd0);
    check("post_rst_cur_ts",   1, 33'(cur_ts[1]), 33'd1);
    check("post_rst_st_ready", 1, 33'(st_ready[1]), 33'd1);

    send_rx(0, 5, 2, 1'b0);
    check("bad_dest_err", 0, 33'(err[0]), 33'd1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
